// File: rtl/uc_2_mem_stage.sv
// rtl/uc_2_mem_stage.sv - memory-access control stage after UC_1: wait-state handshake, stall request, write-back delivery
// Optional STALL_CNT output when UC2_STALL_CNT_EN is defined.
module uc_2_mem_stage #(
    parameter int SELC_W      = 6,
    parameter int TYPE_W      = 7,
    parameter int SELC_NOP    = 35,
    parameter int TO_W        = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              CK3,
    input  logic              RESET_N,
    input  logic [SELC_W-1:0] SelC_in,
    input  logic [TYPE_W-1:0] Type_in,
    input  logic              MR_IN,
    input  logic              MW_IN,
    input  logic              MEM_RDY,
    output logic              MEM_RD,
    output logic              MEM_WR,
    output logic              HOLD_REQ_N,
    output logic [SELC_W-1:0] SelC_wb,
    output logic [TYPE_W-1:0] Type_wb,
    output logic              WE_wb,
    output logic              BUS_ERR
`ifdef UC2_STALL_CNT_EN
    ,
    output logic [15:0]       STALL_CNT
`endif
);

    localparam logic [SELC_W-1:0] NOP    = SELC_W'(SELC_NOP);
    localparam logic [TO_W:0]     TO_CMP = (TO_W+1)'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_WR_WAIT,
        ST_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [TO_W:0]     cnt_inc;
    logic [SELC_W-1:0] selc_cap_q, selc_cap_d;
    logic [TYPE_W-1:0] type_cap_q, type_cap_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              hold_n_q, hold_n_d;
    logic [SELC_W-1:0] selc_wb_q, selc_wb_d;
    logic [TYPE_W-1:0] type_wb_q, type_wb_d;
    logic              we_q, we_d;
    logic              bus_err_q, bus_err_d;

    assign cnt_inc = {1'b0, cnt_q} + (TO_W+1)'(1);

    always_comb begin
        // Default output is a bubble with no stall; each state overrides what it needs.
        state_d    = state_q;
        cnt_d      = cnt_q;
        selc_cap_d = selc_cap_q;
        type_cap_d = type_cap_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        hold_n_d   = 1'b1;
        selc_wb_d  = NOP;
        type_wb_d  = '0;
        we_d       = 1'b0;
        bus_err_d  = bus_err_q;

        case (state_q)
            ST_IDLE: begin
                if (MR_IN && MW_IN) begin
                    state_d   = ST_ERR;
                    bus_err_d = 1'b1;
                    hold_n_d  = 1'b0;
                end else if (MR_IN || MW_IN) begin
                    selc_cap_d = SelC_in;
                    type_cap_d = Type_in;
                    cnt_d      = '0;
                    rd_d       = MR_IN;
                    wr_d       = MW_IN;
                    hold_n_d   = 1'b0;
                    state_d    = MR_IN ? ST_RD_WAIT : ST_WR_WAIT;
                end else begin
                    selc_wb_d = SelC_in;
                    type_wb_d = Type_in;
                    we_d      = (SelC_in != NOP);
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                if (MEM_RDY) begin
                    state_d   = ST_IDLE;
                    type_wb_d = type_cap_q;
                    if (state_q == ST_RD_WAIT) begin
                        selc_wb_d = selc_cap_q;
                        we_d      = (selc_cap_q != NOP);
                    end
                end else if (cnt_inc == TO_CMP) begin
                    // Acknowledge on this same edge would have won; only a silent bus times out.
                    state_d   = ST_ERR;
                    bus_err_d = 1'b1;
                    hold_n_d  = 1'b0;
                end else begin
                    cnt_d    = cnt_inc[TO_W-1:0];
                    rd_d     = (state_q == ST_RD_WAIT);
                    wr_d     = (state_q == ST_WR_WAIT);
                    hold_n_d = 1'b0;
                end
            end
            ST_ERR: begin
                hold_n_d  = 1'b0;
                bus_err_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge CK3 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            selc_cap_q <= NOP;
            type_cap_q <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            hold_n_q   <= 1'b1;
            selc_wb_q  <= NOP;
            type_wb_q  <= '0;
            we_q       <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            selc_cap_q <= selc_cap_d;
            type_cap_q <= type_cap_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            hold_n_q   <= hold_n_d;
            selc_wb_q  <= selc_wb_d;
            type_wb_q  <= type_wb_d;
            we_q       <= we_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign MEM_RD     = rd_q;
    assign MEM_WR     = wr_q;
    assign HOLD_REQ_N = hold_n_q;
    assign SelC_wb    = selc_wb_q;
    assign Type_wb    = type_wb_q;
    assign WE_wb      = we_q;
    assign BUS_ERR    = bus_err_q;

`ifdef UC2_STALL_CNT_EN
    logic [15:0] stall_q;

    // Counts edges on which the registered stall request is active, saturating.
    always_ff @(negedge CK3 or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_q <= '0;
        end else if (!hold_n_q && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign STALL_CNT = stall_q;
`endif

endmodule

// File: tb/tb_uc_2_mem_stage.sv
// tb/tb_uc_2_mem_stage.sv - self-checking bench for uc_2_mem_stage against a transaction-level model
module tb_uc_2_mem_stage;

    logic       CK3 = 1'b1;
    logic       RESET_N = 1'b0;
    logic [5:0] SelC_in = 6'd35;
    logic [6:0] Type_in = '0;
    logic       MR_IN = 1'b0;
    logic       MW_IN = 1'b0;
    logic       MEM_RDY = 1'b0;
    logic       MEM_RD, MEM_WR, HOLD_REQ_N, WE_wb, BUS_ERR;
    logic [5:0] SelC_wb;
    logic [6:0] Type_wb;
`ifdef UC2_STALL_CNT_EN
    logic [15:0] STALL_CNT;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    uc_2_mem_stage dut (
        .CK3       (CK3),
        .RESET_N   (RESET_N),
        .SelC_in   (SelC_in),
        .Type_in   (Type_in),
        .MR_IN     (MR_IN),
        .MW_IN     (MW_IN),
        .MEM_RDY   (MEM_RDY),
        .MEM_RD    (MEM_RD),
        .MEM_WR    (MEM_WR),
        .HOLD_REQ_N(HOLD_REQ_N),
        .SelC_wb   (SelC_wb),
        .Type_wb   (Type_wb),
        .WE_wb     (WE_wb),
        .BUS_ERR   (BUS_ERR)
`ifdef UC2_STALL_CNT_EN
        ,
        .STALL_CNT (STALL_CNT)
`endif
    );

    always #5 CK3 = ~CK3;

    // Model: an outstanding access (none/read/write), its wait count, and a dead flag after any error.
    int          busy;
    int          waits;
    bit          dead;
    int unsigned cap_selc, cap_type;
    int unsigned m_rd, m_wr, m_hold_n, m_selc, m_type, m_we, m_err, m_stall;

    task automatic model_bubble();
        m_selc = 35; m_type = 0; m_we = 0;
    endtask

    always @(negedge CK3 or negedge RESET_N) begin
        if (!RESET_N) begin
            busy = 0; waits = 0; dead = 0; cap_selc = 35; cap_type = 0;
            m_rd = 0; m_wr = 0; m_hold_n = 1; m_err = 0; m_stall = 0;
            model_bubble();
        end else begin
            if (m_hold_n == 0 && m_stall < 65535) m_stall++;
            if (dead) begin
                m_rd = 0; m_wr = 0; m_hold_n = 0; model_bubble();
            end else if (busy != 0) begin
                if (MEM_RDY) begin
                    m_type = cap_type;
                    m_selc = (busy == 1) ? cap_selc : 35;
                    m_we   = (busy == 1 && cap_selc != 35) ? 1 : 0;
                    m_rd = 0; m_wr = 0; m_hold_n = 1; busy = 0;
                end else begin
                    waits++;
                    if (waits == 15) begin
                        dead = 1; m_err = 1; m_rd = 0; m_wr = 0; m_hold_n = 0;
                    end
                    model_bubble();
                end
            end else if (MR_IN && MW_IN) begin
                dead = 1; m_err = 1; m_hold_n = 0; model_bubble();
            end else if (MR_IN || MW_IN) begin
                busy = MR_IN ? 1 : 2; waits = 0;
                cap_selc = SelC_in; cap_type = Type_in;
                m_rd = MR_IN; m_wr = MW_IN; m_hold_n = 0; model_bubble();
            end else begin
                m_selc = SelC_in; m_type = Type_in; m_we = (SelC_in != 35) ? 1 : 0;
                m_hold_n = 1;
            end
        end
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CK3) begin
        if (chk_en) begin
            chk("cmp_mem_rd",  MEM_RD,     m_rd);
            chk("cmp_mem_wr",  MEM_WR,     m_wr);
            chk("cmp_hold_n",  HOLD_REQ_N, m_hold_n);
            chk("cmp_selc_wb", SelC_wb,    m_selc);
            chk("cmp_type_wb", Type_wb,    m_type);
            chk("cmp_we_wb",   WE_wb,      m_we);
            chk("cmp_bus_err", BUS_ERR,    m_err);
`ifdef UC2_STALL_CNT_EN
            chk("cmp_stall",   STALL_CNT,  m_stall);
`endif
        end
    end

    task automatic step();
        @(posedge CK3);
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        MR_IN = 0; MW_IN = 0; MEM_RDY = 0;
        step();
        RESET_N = 1'b1;
    endtask

    int hi;

    initial begin
        step();
        step();
        chk("reset_rd",    MEM_RD, 0);
        chk("reset_hold",  HOLD_REQ_N, 1);
        chk("reset_selc",  SelC_wb, 35);
        chk("reset_type",  Type_wb, 0);
        chk("reset_we",    WE_wb, 0);
        chk("reset_err",   BUS_ERR, 0);
        RESET_N = 1'b1;
        chk_en  = 1'b1;

        // pass-through
        SelC_in = 6'd5; Type_in = 7'h12;
        step();
        chk("pt_selc", SelC_wb, 5);
        chk("pt_type", Type_wb, 7'h12);
        chk("pt_we",   WE_wb, 1);
        SelC_in = 6'd35;
        step();
        chk("pt_nop_we",   WE_wb, 0);
        chk("pt_nop_selc", SelC_wb, 35);

        // read with three wait edges
        SelC_in = 6'd9; Type_in = 7'h21; MR_IN = 1; MEM_RDY = 0;
        step();
        hi = MEM_RD;
        chk("rd_entry_hold", HOLD_REQ_N, 0);
        chk("rd_entry_we",   WE_wb, 0);
        MR_IN = 0;
        for (int i = 0; i < 3; i++) begin
            SelC_in = 6'($urandom_range(0, 63));
            step();
            hi += MEM_RD;
            chk("rd_wait_hold", HOLD_REQ_N, 0);
        end
        MEM_RDY = 1; SelC_in = 6'd35;
        step();
        chk("rd_pulse_len", hi, 4);
        chk("rd_done_rd",   MEM_RD, 0);
        chk("rd_done_selc", SelC_wb, 9);
        chk("rd_done_type", Type_wb, 7'h21);
        chk("rd_done_we",   WE_wb, 1);
        chk("rd_done_hold", HOLD_REQ_N, 1);
`ifdef UC2_STALL_CNT_EN
        chk("rd_stall_cnt", STALL_CNT, 4);
`endif
        MEM_RDY = 0;
        step();
        chk("rd_we_one_cycle", WE_wb, 0);

        // write, acknowledged on the first wait edge
        MW_IN = 1; SelC_in = 6'd35; Type_in = 7'h44;
        step();
        chk("wr_entry_wr", MEM_WR, 1);
        chk("wr_entry_selc", SelC_wb, 35);
        MW_IN = 0; MEM_RDY = 1;
        step();
        chk("wr_done_wr",   MEM_WR, 0);
        chk("wr_done_selc", SelC_wb, 35);
        chk("wr_done_type", Type_wb, 7'h44);
        chk("wr_done_we",   WE_wb, 0);
        MEM_RDY = 0;
        step();

        // acknowledge exactly on the 15th wait edge
        MR_IN = 1; SelC_in = 6'd20; Type_in = 7'h03;
        step();
        MR_IN = 0;
        for (int i = 1; i <= 14; i++) step();
        chk("bnd_still_rd", MEM_RD, 1);
        MEM_RDY = 1;
        step();
        chk("bnd_err",  BUS_ERR, 0);
        chk("bnd_selc", SelC_wb, 20);
        chk("bnd_we",   WE_wb, 1);
        MEM_RDY = 0;
        step();

        // timeout
        MR_IN = 1; SelC_in = 6'd11;
        step();
        MR_IN = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (i == 14) chk("to_pre_err", BUS_ERR, 0);
        end
        chk("to_err",  BUS_ERR, 1);
        chk("to_rd",   MEM_RD, 0);
        chk("to_hold", HOLD_REQ_N, 0);
        MEM_RDY = 1;
        for (int i = 0; i < 3; i++) step();
        chk("err_sticky", BUS_ERR, 1);
        chk("err_hold",   HOLD_REQ_N, 0);
        chk("err_we",     WE_wb, 0);
        RESET_N = 0;
        #1;
        chk("err_reset_clear", BUS_ERR, 0);
        chk("err_reset_hold",  HOLD_REQ_N, 1);
        do_reset();

        // illegal MR+MW
        MR_IN = 1; MW_IN = 1; SelC_in = 6'd3;
        step();
        chk("ill_err", BUS_ERR, 1);
        chk("ill_rd",  MEM_RD, 0);
        chk("ill_wr",  MEM_WR, 0);
        chk("ill_we",  WE_wb, 0);
        do_reset();

        // async reset in the middle of a read
        MR_IN = 1; SelC_in = 6'd9;
        step();
        MR_IN = 0;
        step();
        RESET_N = 0;
        #1;
        chk("async_rd",   MEM_RD, 0);
        chk("async_hold", HOLD_REQ_N, 1);
        chk("async_selc", SelC_wb, 35);
`ifdef UC2_STALL_CNT_EN
        chk("async_stall", STALL_CNT, 0);
`endif
        step();
        RESET_N = 1;

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            bit slow;
            slow = ((n / 200) % 3) == 2;
            r = $urandom_range(0, 31);
            MR_IN = (r < 4) || (r == 8);
            MW_IN = (r >= 4 && r < 7) || (r == 8);
            SelC_in = ($urandom_range(0, 5) == 0) ? 6'd35 : 6'($urandom_range(0, 63));
            Type_in = 7'($urandom);
            MEM_RDY = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
            if (dead && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 499) == 0) begin
                RESET_N = 0;
                #1;
                chk("rand_async_hold", HOLD_REQ_N, 1);
                step();
                RESET_N = 1;
            end else begin
                step();
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uc_2_mem_stage.md
Name: uc_2_mem_stage

Overview:
- Pipeline control stage directly downstream of the UC_1 control-latch stage.
- Consumes the destination select (SelC), instruction type (Type) and memory read/write flags (MR/MW) that UC_1 produces.
- Sequences the data-memory access with a wait-state handshake and requests an upstream stall while memory is busy.
- Delivers the write-back destination and type to the register-file stage; destination 35 (SELC_NOP) means "no write".

Parameters:
- SELC_W, 6, width of the destination select.
- TYPE_W, 7, width of the instruction type.
- SELC_NOP, 35, destination code meaning "no register write" (bubble).
- TO_W, 4, width of the memory-timeout counter.
- MEM_TIMEOUT, 15, maximum wait cycles before bus error; must be less than 2^TO_W.

Ports:
- CK3  in  1  stage clock; all state updates on the falling edge.
- RESET_N  in  1  asynchronous active-low reset.
- SelC_in  in  SELC_W  destination from UC_1.
- Type_in  in  TYPE_W  type from UC_1.
- MR_IN  in  1  memory read requested by the current instruction.
- MW_IN  in  1  memory write requested by the current instruction.
- MEM_RDY  in  1  memory acknowledge, sampled on the falling edge of CK3.
- MEM_RD  out  1  registered memory read strobe.
- MEM_WR  out  1  registered memory write strobe.
- HOLD_REQ_N  out  1  registered; 0 requests an upstream stall.
- SelC_wb  out  SELC_W  registered write-back destination.
- Type_wb  out  TYPE_W  registered write-back type.
- WE_wb  out  1  registered register-file write enable.
- BUS_ERR  out  1  sticky error flag.

Behaviour:
- Reset (async, RESET_N=0):
  - state=IDLE.
  - MEM_RD=0, MEM_WR=0, HOLD_REQ_N=1, SelC_wb=SELC_NOP, Type_wb=0, WE_wb=0, BUS_ERR=0.
  - Timeout counter=0; captured SelC/Type=SELC_NOP/0.
  - Reset mid-access aborts the access immediately; strobes drop asynchronously.
- States: IDLE, RD_WAIT, WR_WAIT, ERR.
- IDLE, MR_IN=0 and MW_IN=0 (pass-through):
  - Next edge: SelC_wb=SelC_in, Type_wb=Type_in.
  - WE_wb = (SelC_in != SELC_NOP).
  - Latency is 1 edge.
- IDLE, MR_IN=1, MW_IN=0:
  - Capture SelC_in/Type_in; MEM_RD=1; HOLD_REQ_N=0; counter=0.
  - Output bubble: SelC_wb=SELC_NOP, Type_wb=0, WE_wb=0.
  - Go to RD_WAIT.
- IDLE, MW_IN=1, MR_IN=0:
  - Same as the read case but MEM_WR=1; go to WR_WAIT.
- IDLE, MR_IN=1 and MW_IN=1:
  - Illegal combination: go to ERR, BUS_ERR=1, no strobe asserted.
- RD_WAIT / WR_WAIT, MEM_RDY=1:
  - Strobe drops; HOLD_REQ_N=1; go to IDLE.
  - Read completion: SelC_wb/Type_wb=captured values, WE_wb=(captured SelC != SELC_NOP), for exactly 1 cycle.
  - Write completion: SelC_wb=SELC_NOP, Type_wb=captured Type, WE_wb=0.
- RD_WAIT / WR_WAIT, MEM_RDY=0:
  - Counter increments; outputs hold the bubble.
  - Inputs are ignored while waiting; upstream is stalled.
- Timeout:
  - Counter == MEM_TIMEOUT with MEM_RDY=0 at the same edge: go to ERR.
  - If MEM_RDY=1 on the timeout edge, MEM_RDY wins.
- ERR (terminal until reset):
  - BUS_ERR=1; MEM_RD=MEM_WR=0; HOLD_REQ_N=0.
  - Outputs hold the bubble; MEM_RDY is ignored.
- MEM_RDY in IDLE is ignored (spurious acknowledge).
- Wait time: minimum 1 wait edge; MEM_RDY is first evaluated on the edge after the strobe is asserted.

Optional Feature:
- Macro UC2_STALL_CNT_EN.
- When defined:
  - Adds output STALL_CNT (16 bits).
  - Increments on every falling edge where HOLD_REQ_N=0, saturating at 16'hFFFF.
  - Clears on reset only.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Pass-through: reset, then SelC_in=5, Type_in=7'h12, MR/MW=0 -> next edge SelC_wb=5, Type_wb=7'h12, WE_wb=1; with SelC_in=35 -> WE_wb=0.
- Read with wait states: SelC_in=9, MR_IN=1, MEM_RDY low 3 edges then high -> MEM_RD=1 and HOLD_REQ_N=0 for 4 cycles; then SelC_wb=9, WE_wb=1 for one cycle; HOLD_REQ_N=1.
- Write: MW_IN=1, SelC_in=35, MEM_RDY high on the first wait edge -> MEM_WR pulse of 1 cycle; WE_wb=0, SelC_wb=35 throughout.
- Timeout: MR_IN=1, MEM_RDY held low -> after 15 wait edges BUS_ERR=1, MEM_RD=0, HOLD_REQ_N=0; a later MEM_RDY=1 has no effect; RESET_N pulse clears everything.
- Illegal and timeout-boundary cases:
  - MR_IN=MW_IN=1 -> ERR next edge, no strobes.
  - Separately, MEM_RDY=1 exactly on the 15th wait edge -> normal completion, BUS_ERR=0.
- Async reset mid-read: RESET_N low between edges during RD_WAIT -> MEM_RD=0, HOLD_REQ_N=1, SelC_wb=35 immediately. With UC2_STALL_CNT_EN defined, STALL_CNT=0 after reset and equals 4 after the read-with-wait-states scenario.
